fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RV32E core. Holds the fetch PC, drives the address of the combinational program ROM, and captures each returned word with its PC into a small instruction buffer. Delivers instructions to decode over a valid/ready handshake, and takes PC redirects (branches/jumps) from execute, which flush the buffer.

## Interface
- `RESET_PC`, default `32'h0000_0000`: fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: instruction buffer entries; a power of two, at least 2.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `addr_bus`, output, 32: byte address to the program ROM, always word-aligned.
- `data_bus`, input, 32: ROM read data, valid in the same cycle as `addr_bus`.
- `redirect_valid`, input, 1: execute requests a PC change this cycle.
- `redirect_pc`, input, 32: redirect target.
- `inst_valid`, output, 1: the buffer head holds an instruction.
- `inst_ready`, input, 1: decode accepts the head this cycle.
- `inst`, output, 32: head instruction word.
- `inst_pc`, output, 32: PC of the head instruction.
- `redirect_misaligned`, output, 1: one-cycle registered pulse, set when an accepted redirect had `redirect_pc[1:0] != 0`.

## Operation
- State:
  - `fetch_pc` register.
  - `DEPTH`-entry FIFO of {inst, pc} with read pointer, write pointer and count.
  - `redirect_misaligned` flop.
- `addr_bus = fetch_pc`, driven directly from the register. There is no combinational path from any input to `addr_bus`.
- Push condition: no redirect, and either `count < DEPTH`, or `count == DEPTH` with a pop in the same cycle.
- On push:
  - Write {`data_bus`, `fetch_pc`} at the write pointer.
  - Set `fetch_pc <= fetch_pc + 4`, modulo 2^32, so `32'hFFFF_FFFC` wraps to 0.
- Pop condition: `inst_valid && inst_ready`. The read pointer advances.
- Simultaneous push and pop leave count unchanged. Push and pop both occur when full.
- Redirect has top priority:
  - Set `count <= 0` and both pointers to 0.
  - Set `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - No push that cycle.
  - A pop in the same cycle counts as taken by decode. Whether to squash it is decode's concern.
- `redirect_misaligned <= redirect_valid & |redirect_pc[1:0]`. The aligned target is still used.
- `inst_valid = (count != 0)`, registered state only.
- `inst` and `inst_pc` are driven from the head entry. They are 0 when the buffer is empty after reset or flush: entries are cleared on reset and flush.
- Stall: with `inst_ready` low and the buffer full, `fetch_pc` holds and `addr_bus` stays stable.

## Timing
- Reset values: `fetch_pc = RESET_PC`, `addr_bus = RESET_PC`, `count = 0`, `inst_valid = 0`, `inst = 0`, `inst_pc = 0`, `redirect_misaligned = 0`.
- Latency from `addr_bus` to `inst_valid` is 1 cycle: the word is captured on the edge and visible the next cycle.
- First `inst_valid` is high after the first rising edge following `rst_n` deassertion.
- Redirect at edge N:
  - `inst_valid = 0` in cycle N+1.
  - `addr_bus` equals the target in cycle N+1.
  - The target instruction is valid in cycle N+2 (2-cycle bubble).
- Throughput: one instruction per cycle while `inst_ready` stays high.
- Reset asserted mid-operation forces all reset values immediately, independent of `clk`. The buffer contents are lost.

## Structure
- Shared package `rv32e_pkg` holds:
  - `XLEN = 32`.
  - Default reset vector.
  - Instruction word type.
  - `I_NOP` and opcode constants (`OP_AUIPC`, ...), which also serve the ROM and decode.
- One sub-module, `fetch_fifo`: parameterised synchronous FIFO with a flush input, storing 64-bit {pc, inst} entries.
- `fetch_unit` contains only the PC logic, push/pop qualification and the misaligned flag.

## Test plan
- Reset release against a ROM holding three AUIPC words then NOPs, `inst_ready = 1`:
  - `inst_pc` = 0, 4, 8, 12 on consecutive cycles starting cycle 1.
  - `inst` = the AUIPC x1, x2, x3 encodings, then `32'h0000_0013`.
- `inst_ready = 0` for 5 cycles:
  - `inst_valid` stays 1 and `inst_pc` holds 0.
  - `addr_bus` freezes at 8 (DEPTH 2).
  - After `inst_ready` rises, `inst_pc` runs 0, 4, 8 with no gap or duplicate.
- `redirect_valid = 1`, `redirect_pc = 32'h40` while the buffer is full:
  - Next cycle `inst_valid = 0` and `addr_bus = 32'h40`.
  - The cycle after, `inst_pc = 32'h40`.
- `redirect_pc = 32'h42`:
  - `redirect_misaligned` pulses high for exactly one cycle.
  - Fetch resumes at `32'h40`.
- Redirect to `32'hFFFF_FFF8` with ROM reads returning NOP: `inst_pc` = `FFFF_FFF8`, `FFFF_FFFC`, `0000_0000`.
- Assert `rst_n = 0` asynchronously mid-cycle with the buffer full: all outputs reach their reset values before the next clock edge.

Source files
------------

// File: rtl/rv32e_pkg.sv
// Shared RV32E definitions used by fetch, decode and the program ROM.
package rv32e_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef logic [XLEN-1:0] inst_t;
    typedef logic [XLEN-1:0] addr_t;

    // addi x0, x0, 0
    localparam inst_t I_NOP = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } fetch_entry_t;

    function automatic addr_t pc_next(input addr_t pc);
        return pc + 32'd4;
    endfunction

    function automatic addr_t pc_align(input addr_t pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM port, execute redirect and decode handshake.
interface fetch_unit_if;
    import rv32e_pkg::*;

    addr_t addr_bus;
    inst_t data_bus;
    logic  redirect_valid;
    addr_t redirect_pc;
    logic  inst_valid;
    logic  inst_ready;
    inst_t inst;
    addr_t inst_pc;
    logic  redirect_misaligned;

    modport master (
        output addr_bus,
        input  data_bus,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output redirect_misaligned
    );

    modport slave (
        input  addr_bus,
        output data_bus,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  redirect_misaligned
    );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, inst} with a flush that clears
// every entry, so the head reads as zero whenever the buffer was just emptied.
module fetch_fifo
    import rv32e_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// RV32E fetch stage: fetch PC, ROM addressing, instruction buffer handoff to
// decode, and redirect handling from execute.
module fetch_unit
    import rv32e_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
    parameter int              DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    addr_t        fetch_pc;
    logic         misaligned_q;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    assign pop  = bus.inst_valid && bus.inst_ready;
    // A full buffer can still take the word when decode drains the head this cycle.
    assign push = !bus.redirect_valid && (!fifo_full || pop);

    assign wr_entry = '{pc: fetch_pc, inst: bus.data_bus};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            fetch_pc <= pc_align(bus.redirect_pc);
        end else if (push) begin
            fetch_pc <= pc_next(fetch_pc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= bus.redirect_valid & (|bus.redirect_pc[1:0]);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.addr_bus            = fetch_pc;
    assign bus.inst_valid          = !fifo_empty;
    assign bus.inst                = head.inst;
    assign bus.inst_pc             = head.pc;
    assign bus.redirect_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random redirect
// and stall traffic against a queue-based reference model.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk;
    logic rst_n;
    logic rom_rand;

    int n_checks;
    int n_fail;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_mis;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a, input logic rnd);
        if (rnd) begin
            return {a[15:0] ^ 16'h5A3C, a[31:16] ^ a[17:2]};
        end
        case (a)
            32'h0000_0000: return 32'h0000_0097;
            32'h0000_0004: return 32'h0000_0117;
            32'h0000_0008: return 32'h0000_0197;
            default:       return 32'h0000_0013;
        endcase
    endfunction

    assign bus.data_bus = rom_word(bus.addr_bus, rom_rand);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc  = 32'h0000_0000;
        m_mis = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_addr"},  bus.addr_bus, 32'h0);
        check_eq({tag, "_valid"}, 32'(bus.inst_valid), 32'h0);
        check_eq({tag, "_inst"},  bus.inst, 32'h0);
        check_eq({tag, "_pc"},    bus.inst_pc, 32'h0);
        check_eq({tag, "_mis"},   32'(bus.redirect_misaligned), 32'h0);
    endtask

    // One clock: compare DUT to model, apply inputs, advance model, cross the edge.
    task automatic do_cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic pop;
        @(negedge clk);
        check_eq("m_addr",  bus.addr_bus, m_pc);
        check_eq("m_valid", 32'(bus.inst_valid), 32'(mq.size() != 0));
        check_eq("m_mis",   32'(bus.redirect_misaligned), 32'(m_mis));
        if (mq.size() != 0) begin
            check_eq("m_inst",    bus.inst, mq[0].inst);
            check_eq("m_inst_pc", bus.inst_pc, mq[0].pc);
        end
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.inst_ready     = rdy;
        pop   = (mq.size() != 0) && rdy;
        m_mis = rv && (rpc[1:0] != 2'b00);
        if (rv) begin
            mq.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (pop) void'(mq.pop_front());
            if (mq.size() < DEPTH) begin
                mq.push_back('{pc: m_pc, inst: rom_word(m_pc, rom_rand)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_inst [4];
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;

        exp_inst[0] = 32'h0000_0097;
        exp_inst[1] = 32'h0000_0117;
        exp_inst[2] = 32'h0000_0197;
        exp_inst[3] = 32'h0000_0013;
        n_checks = 0;
        n_fail   = 0;
        rom_rand = 1'b0;
        rst_n    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Reset release: three AUIPCs then NOPs, one per cycle.
        for (int k = 0; k < 4; k++) begin
            do_cycle(1'b0, 32'h0, 1'b1);
            check_eq("boot_pc",   bus.inst_pc, 32'(4 * k));
            check_eq("boot_inst", bus.inst, exp_inst[k]);
        end

        // Stall with the buffer full: head and addr_bus freeze.
        do_cycle(1'b1, 32'h0, 1'b1);
        check_eq("rd0_valid", 32'(bus.inst_valid), 32'h0);
        for (int s = 0; s < 5; s++) begin
            do_cycle(1'b0, 32'h0, 1'b0);
            check_eq("stall_valid", 32'(bus.inst_valid), 32'h1);
            check_eq("stall_pc",    bus.inst_pc, 32'h0);
            if (s >= 1) check_eq("stall_addr", bus.addr_bus, 32'h8);
        end
        do_cycle(1'b0, 32'h0, 1'b1);
        check_eq("resume_pc4", bus.inst_pc, 32'h4);
        do_cycle(1'b0, 32'h0, 1'b1);
        check_eq("resume_pc8", bus.inst_pc, 32'h8);

        // Redirect while full.
        do_cycle(1'b0, 32'h0, 1'b0);
        do_cycle(1'b0, 32'h0, 1'b0);
        do_cycle(1'b1, 32'h40, 1'b0);
        check_eq("redir_valid", 32'(bus.inst_valid), 32'h0);
        check_eq("redir_addr",  bus.addr_bus, 32'h40);
        check_eq("redir_inst",  bus.inst, 32'h0);
        check_eq("redir_ipc",   bus.inst_pc, 32'h0);
        do_cycle(1'b0, 32'h0, 1'b1);
        check_eq("redir_tgt_valid", 32'(bus.inst_valid), 32'h1);
        check_eq("redir_tgt_pc",    bus.inst_pc, 32'h40);

        // Misaligned redirect: one-cycle flag, aligned target used.
        do_cycle(1'b1, 32'h42, 1'b1);
        check_eq("mis_hi",   32'(bus.redirect_misaligned), 32'h1);
        check_eq("mis_addr", bus.addr_bus, 32'h40);
        do_cycle(1'b0, 32'h0, 1'b1);
        check_eq("mis_lo",   32'(bus.redirect_misaligned), 32'h0);
        check_eq("mis_tgt",  bus.inst_pc, 32'h40);

        // PC wrap at the top of the address space.
        do_cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
        do_cycle(1'b0, 32'h0, 1'b1);
        check_eq("wrap_pc0",   bus.inst_pc, 32'hFFFF_FFF8);
        check_eq("wrap_inst0", bus.inst, 32'h0000_0013);
        do_cycle(1'b0, 32'h0, 1'b1);
        check_eq("wrap_pc1",   bus.inst_pc, 32'hFFFF_FFFC);
        check_eq("wrap_inst1", bus.inst, 32'h0000_0013);
        do_cycle(1'b0, 32'h0, 1'b1);
        check_eq("wrap_pc2",   bus.inst_pc, 32'h0000_0000);

        // Random redirects, stalls and ROM contents.
        rom_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 9) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            rdy = ($urandom_range(0, 2) != 0);
            do_cycle(rv, rpc, rdy);
        end

        // Asynchronous reset mid-cycle with a full buffer.
        do_cycle(1'b0, 32'h0, 1'b0);
        do_cycle(1'b0, 32'h0, 1'b0);
        check_eq("pre_arst_valid", 32'(bus.inst_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("arst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b0, 32'h0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
